// File: rtl/count_share_arbiter_pkg.sv
// Shared types and constants for the counter-sharing arbiter.
package count_share_arbiter_pkg;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned REM_W = 4;

  localparam logic MODE_ODD  = 1'b1;
  localparam logic MODE_EVEN = 1'b0;

  localparam int unsigned LEN_ZERO_MEANS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Burst length in steps; an encoded zero stands for the full eight steps.
  function automatic logic [REM_W-1:0] burst_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? REM_W'(LEN_ZERO_MEANS) : {1'b0, len};
  endfunction

endpackage

// File: rtl/count_share_arbiter_count_core.sv
// Parity-switching up-counter: +1 on a misaligned first step, +2 otherwise.
module count_core
  import count_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             first,
  input  logic             control,
  output logic [WIDTH-1:0] count,
  output logic             odd_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_c;

  // Step size: align parity on the first step of a burst, otherwise stay on parity.
  always_comb begin
    step_c  = WIDTH'(2);
    if (first && (count_q[0] != control)) begin
      step_c = WIDTH'(1);
    end
    count_d = count_q + step_c;
  end

  // Counter register; holds whenever no burst is stepping it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign odd_flag = count_q[0];

endmodule

// File: rtl/count_share_arbiter.sv
// Round-robin arbiter sequencing bursts of a shared parity counter for two requesters.
module count_share_arbiter
  import count_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       mode,
  input  logic [2:0]       len0,
  input  logic [2:0]       len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             control,
  output logic [WIDTH-1:0] count,
  output logic             odd_flag
);

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             busy_q;
  logic             control_q;
  logic [REM_W-1:0] rem_q;
  logic             prio_q;   // requester index holding round-robin priority
  logic             first_q;  // next counter step is the first of the burst
  logic             win_c;

  // Winner selection: a lone request wins outright, a tie goes to the priority holder.
  always_comb begin
    win_c = prio_q;
    if (req == 2'b01) begin
      win_c = 1'b0;
    end else if (req == 2'b10) begin
      win_c = 1'b1;
    end
  end

  // Sequencer FSM with registered grant, done, busy and control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      control_q <= MODE_EVEN;
      rem_q     <= '0;
      prio_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q   <= ST_RUN;
            gnt_q     <= win_c ? 2'b10 : 2'b01;
            busy_q    <= 1'b1;
            control_q <= mode[win_c];
            rem_q     <= burst_len(win_c ? len1 : len0);
            first_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          first_q <= 1'b0;
          rem_q   <= rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= gnt_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          prio_q  <= gnt_q[0];
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == ST_RUN),
    .first    (first_q),
    .control  (control_q),
    .count    (count),
    .odd_flag (odd_flag)
  );

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign control = control_q;

endmodule

// File: doc/count_share_arbiter.md
# count_share_arbiter

Round-robin arbiter and sequencer that shares one 3-bit parity-switching up-counter between two requesters. Each requester asks for a burst of counter steps in odd or even mode. The block grants the counter to one requester at a time, drives the counter's `control` and step enable for the burst length, and signals completion. It sits between the CPU's sequencing logic and the count-up/switcher datapath.

## Interface
- `WIDTH`, 3: counter width; `count` wraps modulo 2^WIDTH.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 2: per-requester request; held high until that requester's `done`.
- `mode` input 2: per-requester mode, 1 = odd sequence, 0 = even sequence; sampled at grant.
- `len0` input 3: requester 0 burst length in steps; 0 means 8; sampled at grant.
- `len1` input 3: requester 1 burst length; same encoding.
- `gnt` output 2: one-hot grant; high from grant through the DONE cycle.
- `done` output 2: one-cycle completion pulse to the granted requester.
- `busy` output 1: high whenever state is not IDLE.
- `control` output 1: mode currently applied to the counter (1 = odd).
- `count` output WIDTH: counter value.
- `odd_flag` output 1: equals `count[0]`.

## Operation
- States:
  - IDLE: no grant.
  - RUN: counter steps once per cycle.
  - DONE: `done` high, `gnt` still high.
- IDLE transitions:
  - At a clock edge with any `req` high, pick the winner, register `gnt`, latch the winner's `mode` into `control`, latch its length into `remaining`, and go to RUN.
  - With no request, `count` and `control` hold.
- Arbitration:
  - Round-robin. The requester not served last has priority.
  - After reset, requester 0 has priority.
  - If both requests are high at once, the priority holder wins. The loser waits with `req` held.
- RUN, per edge:
  - `count` advances and `remaining` decrements.
  - On the edge where `remaining` == 1, take the final step and go to DONE.
- Step rule:
  - First step of a burst: if `count[0]` != `control`, step is +1 (parity alignment). Otherwise step is +2.
  - All later steps are +2.
  - Arithmetic is modulo 8, so odd mode cycles 1,3,5,7,1 and even mode cycles 0,2,4,6,0.
- DONE: counter holds. On the next edge, clear `gnt` and `done` and return to IDLE.
- Requester handshake:
  - The requester must drop `req` in the DONE cycle.
  - If `req` is still high at the DONE→IDLE edge, it is not sampled on that edge. It is arbitrated on the following IDLE edge as a fresh request.
- Inputs from the non-granted requester are ignored until its grant.
- `count` and `control` retain their last values between bursts.

## Timing
- Reset: all outputs are 0 (`gnt`, `done`, `busy`, `control`, `count`, `odd_flag`). State is IDLE and the round-robin pointer points to requester 0.
- Asynchronous reset mid-burst aborts immediately. No `done` is issued and the burst is lost.
- Request to grant: 1 cycle. With `req` high before edge k, `gnt` is high after edge k.
- Burst of N steps: `count` changes after edges k+1 … k+N.
- `done` is high for the single cycle after edge k+N. `gnt` drops after edge k+N+1.
- Minimum back-to-back spacing: 1 IDLE cycle between bursts.
- `odd_flag` is combinational from the registered `count`.

## Structure
- Shared package holds:
  - state encoding (`ST_IDLE`, `ST_RUN`, `ST_DONE`, 2 bits);
  - `MODE_ODD` = 1 and `MODE_EVEN` = 0;
  - `LEN_ZERO_MEANS` = 8.
- One sub-module, `count_core`, contains the counter and step rule:
  - inputs: `clk`, `rst_n`, `en`, `first`, `control`;
  - outputs: `count`, `odd_flag`.
- The arbiter, FSM and `remaining` down-counter (4 bits, to hold 8) sit in the top level.

## Test plan
- Reset, then requester 0 with `mode`=1, `len0`=3: `gnt`=01 one cycle later; `count` steps 1,3,5; `done`=01 for one cycle; `count` holds 5.
- Both requests high after reset, requester 0 `mode`=0 `len0`=2, requester 1 `mode`=1 `len1`=2:
  - requester 0 served first, `count` 2,4;
  - after one IDLE cycle, `gnt`=10 and `count` steps 5,7.
- `len0`=0 in even mode from `count`=6: 8 steps 0,2,4,6,0,2,4,6, then `done`.
- Requester 1 keeps `req` high after its `done` while requester 0 also requests: requester 0 wins next, since round-robin gives it priority.
- Assert `rst_n` low mid-burst at `count`=3: all outputs 0 at once, no `done`; after release, a new request starts from `count`=0.
- Odd burst ending at 7 followed by another odd burst of 2: `count` wraps 1,3, with no alignment step.
